score_counter: RTL and testbench
================================

SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 8: frame ticks of continuous move-hold per score increment (legal range 1..255).
REQ-002 SHALL have parameter MAX_SCORE, default 99: saturation value; never above 127.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_frame_tick  input  1  one-cycle pulse per video frame; synchronous to i_clk.
REQ-006 SHALL have port i_move  input  1  raw move-button level, asynchronous to i_clk.
REQ-007 SHALL have port i_collision  input  1  level; player hit an obstacle; synchronous to i_clk.
REQ-008 SHALL have port i_restart  input  1  one-cycle restart request; synchronous to i_clk.
REQ-009 SHALL have port o_score  output  7  current score, binary, registered; feeds the score renderer's i_score.
REQ-010 SHALL have port o_high_score  output  7  best score since reset, registered.
REQ-011 SHALL have port o_game_over  output  1  high while in OVER state.
REQ-012 SHALL have port o_score_pulse  output  1  one-cycle pulse in the cycle o_score changes by an increment.

Function
REQ-013 SHALL pass i_move through a 2-flop synchronizer; "move" below means the synchronized level (2-cycle latency).
REQ-014 SHALL implement states READY, PLAY, OVER.
REQ-015 READY: o_score = 0; move high for 1 cycle -> PLAY; hold count = 0.
REQ-016 PLAY: on i_frame_tick with move high, hold count += 1; when the count reaches HOLD_TICKS, it clears to 0 and o_score increments in the same update.
REQ-017 PLAY: move low clears the hold count to 0 in the next cycle; partial holds SHALL NOT carry over.
REQ-018 o_score SHALL saturate at MAX_SCORE: further completed holds leave o_score unchanged and assert no o_score_pulse.
REQ-019 o_score and o_score_pulse SHALL update 1 cycle after the qualifying i_frame_tick cycle.
REQ-020 PLAY with i_collision high -> OVER next cycle; o_score freezes.
REQ-021 Collision and a completing frame tick in the same cycle: collision wins; no increment, no pulse.
REQ-022 On PLAY->OVER: if o_score > o_high_score, o_high_score <= o_score in the same edge; ties leave it unchanged.
REQ-023 OVER: o_game_over = 1; move, i_frame_tick and i_collision are ignored.
REQ-024 OVER with i_restart -> READY next cycle: o_score <= 0, hold count <= 0, o_high_score retained.
REQ-025 i_restart outside OVER SHALL be ignored; i_collision outside PLAY SHALL be ignored.
REQ-026 Hold counter width SHALL be 8 bits; it never exceeds HOLD_TICKS.

Reset
REQ-027 i_rst high at a clock edge SHALL force READY, o_score = 0, o_high_score = 0, o_game_over = 0, o_score_pulse = 0, hold count = 0, synchronizer flops = 0.
REQ-028 Reset SHALL override all other inputs in the same cycle, including mid-hold and in OVER.
REQ-029 All outputs SHALL be driven from flops; no combinational input-to-output path.

Structure
REQ-030 State encoding, SCORE_W = 7 and the default MAX_SCORE SHALL live in shared package score_pkg, reused by the renderer and top level.
REQ-031 The hold counter plus completion detect SHALL be sub-module hold_timer (inputs: clk, rst, clear, tick, move; output: done pulse).
REQ-032 Implementation SHALL be 120-400 lines of RTL with no latches and a single clock domain after the synchronizer.

Verification (HOLD_TICKS=4, MAX_SCORE=99)
REQ-033 Reset, move held high, 8 frame ticks -> o_score 0->1 after tick 4 and 1->2 after tick 8; exactly 2 o_score_pulse cycles.
REQ-034 Move high for 3 ticks, low for 1 cycle, high again for 3 ticks -> o_score stays 0.
REQ-035 Force score to 98, hold for 12 ticks -> o_score reaches 99 after tick 4 and stays 99; exactly 1 pulse.
REQ-036 Score 5, i_collision coincident with the 4th tick -> o_score stays 5, o_game_over=1 next cycle, o_high_score=5.
REQ-037 OVER with high 5, i_restart, then reach 3 and collide -> o_score 0 after restart, o_high_score stays 5; i_restart in PLAY has no effect.
REQ-038 i_rst asserted in OVER with score 7 and high 7 -> next cycle all outputs 0, state READY.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the score counter, score renderer and top level:
// score width, default saturation value and game state encoding.
package score_pkg;

   localparam int unsigned SCORE_W           = 7;
   localparam int unsigned HOLD_W            = 8;
   localparam int unsigned MAX_SCORE_DEFAULT = 99;

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

endpackage : score_pkg

// File: rtl/hold_timer.sv
// Counts frame ticks of continuous move-hold and flags each completed hold.
// The done flag is combinational and is consumed by the owning FSM's registers.
module hold_timer
   import score_pkg::*;
#(
   parameter int unsigned HOLD_TICKS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   input  logic move,
   output logic done
);

   logic [HOLD_W-1:0] count;
   logic              last_c;

   assign last_c = (count == HOLD_W'(HOLD_TICKS - 1));
   assign done   = ~clear & move & tick & last_c;

   // A released button or an external clear discards any partial hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear || !move) begin
         count <= '0;
      end else if (tick) begin
         if (last_c) count <= '0;
         else        count <= count + HOLD_W'(1);
      end
   end

endmodule : hold_timer

// File: rtl/score_counter.sv
// Game score tracker: scores one point per completed move-hold while playing,
// freezes on collision, keeps the best score since reset.
module score_counter
   import score_pkg::*;
#(
   parameter int unsigned HOLD_TICKS = 8,
   parameter int unsigned MAX_SCORE  = MAX_SCORE_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_frame_tick,
   input  logic               i_move,
   input  logic               i_collision,
   input  logic               i_restart,
   output logic [SCORE_W-1:0] o_score,
   output logic [SCORE_W-1:0] o_high_score,
   output logic               o_game_over,
   output logic               o_score_pulse
);

   logic   move_meta;
   logic   move_sync;
   state_t state;
   state_t state_next;
   logic   clear_c;
   logic   done_c;
   logic   inc_c;
   logic   zero_c;
   logic   capture_c;

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         move_meta <= 1'b0;
         move_sync <= 1'b0;
      end else begin
         move_meta <= i_move;
         move_sync <= move_meta;
      end
   end

   hold_timer #(
      .HOLD_TICKS (HOLD_TICKS)
   ) u_hold_timer (
      .clk   (i_clk),
      .rst   (i_rst),
      .clear (clear_c),
      .tick  (i_frame_tick),
      .move  (move_sync),
      .done  (done_c)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_READY;
      else       state <= state_next;
   end

   // Collision takes priority over a hold completing in the same cycle.
   always_comb begin
      state_next = state;
      clear_c    = 1'b1;
      inc_c      = 1'b0;
      zero_c     = 1'b0;
      capture_c  = 1'b0;
      case (state)
         ST_READY: begin
            if (move_sync) state_next = ST_PLAY;
         end
         ST_PLAY: begin
            clear_c = i_collision;
            if (i_collision) begin
               state_next = ST_OVER;
               capture_c  = (o_score > o_high_score);
            end else begin
               inc_c = done_c && (o_score < SCORE_W'(MAX_SCORE));
            end
         end
         ST_OVER: begin
            if (i_restart) begin
               state_next = ST_READY;
               zero_c     = 1'b1;
            end
         end
         default: state_next = ST_READY;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_score       <= '0;
         o_high_score  <= '0;
         o_game_over   <= 1'b0;
         o_score_pulse <= 1'b0;
      end else begin
         if (zero_c)     o_score <= '0;
         else if (inc_c) o_score <= o_score + SCORE_W'(1);
         if (capture_c)  o_high_score <= o_score;
         o_game_over   <= (state_next == ST_OVER);
         o_score_pulse <= inc_c;
      end
   end

endmodule : score_counter

// File: tb/tb_score_counter.sv
// Bench for score_counter (HOLD_TICKS=4, MAX_SCORE=99): directed game scenarios
// plus random play, all compared every cycle against a behavioural game model.
module tb_score_counter;

   localparam int unsigned HOLD = 4;
   localparam int unsigned MAXS = 99;
   localparam int PH_READY = 0;
   localparam int PH_PLAY  = 1;
   localparam int PH_OVER  = 2;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_frame_tick = 1'b0;
   logic       i_move = 1'b0;
   logic       i_collision = 1'b0;
   logic       i_restart = 1'b0;
   logic [6:0] o_score;
   logic [6:0] o_high_score;
   logic       o_game_over;
   logic       o_score_pulse;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;

   // Reference model: game phase, score, best score, ticks held so far.
   int   m_phase = PH_READY;
   int   m_score = 0;
   int   m_high  = 0;
   int   m_held  = 0;
   int   m_pulse = 0;
   logic m_hist1 = 1'b0;
   logic m_hist2 = 1'b0;

   always #5 i_clk = ~i_clk;

   score_counter #(
      .HOLD_TICKS (HOLD),
      .MAX_SCORE  (MAXS)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_frame_tick  (i_frame_tick),
      .i_move        (i_move),
      .i_collision   (i_collision),
      .i_restart     (i_restart),
      .o_score       (o_score),
      .o_high_score  (o_high_score),
      .o_game_over   (o_game_over),
      .o_score_pulse (o_score_pulse)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic tick, input logic mv,
                             input logic col, input logic rs);
      logic moving;
      if (rst) begin
         m_phase = PH_READY; m_score = 0; m_high = 0; m_held = 0; m_pulse = 0;
         m_hist1 = 1'b0; m_hist2 = 1'b0;
      end else begin
         moving  = m_hist2;
         m_hist2 = m_hist1;
         m_hist1 = mv;
         m_pulse = 0;
         case (m_phase)
            PH_READY: begin
               m_held = 0;
               if (moving) m_phase = PH_PLAY;
            end
            PH_PLAY: begin
               if (col) begin
                  if (m_score > m_high) m_high = m_score;
                  m_phase = PH_OVER;
                  m_held  = 0;
               end else if (!moving) begin
                  m_held = 0;
               end else if (tick) begin
                  m_held++;
                  if (m_held == int'(HOLD)) begin
                     m_held = 0;
                     if (m_score < int'(MAXS)) begin
                        m_score++;
                        m_pulse = 1;
                     end
                  end
               end
            end
            default: begin
               if (rs) begin
                  m_phase = PH_READY;
                  m_score = 0;
                  m_held  = 0;
               end
            end
         endcase
      end
   endtask

   task automatic step(input logic rst, input logic tick, input logic mv,
                       input logic col, input logic rs);
      i_rst = rst; i_frame_tick = tick; i_move = mv; i_collision = col; i_restart = rs;
      @(posedge i_clk);
      model_step(rst, tick, mv, col, rs);
      #1;
      if (o_score_pulse) pulses++;
      chk("score", int'(o_score), m_score);
      chk("high_score", int'(o_high_score), m_high);
      chk("game_over", int'(o_game_over), (m_phase == PH_OVER) ? 1 : 0);
      chk("score_pulse", int'(o_score_pulse), m_pulse);
   endtask

   task automatic enter_play();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic hold_ticks(input int n);
      repeat (n) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic r_rst, r_tick, r_col, r_rs;
      logic r_mv;

      // Reset state
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_score", int'(o_score), 0);
      chk("rst_high", int'(o_high_score), 0);
      chk("rst_over", int'(o_game_over), 0);
      chk("rst_pulse", int'(o_score_pulse), 0);

      // Eight held ticks give two points
      enter_play();
      pulses = 0;
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         if (i == 4) chk("hold4_score", int'(o_score), 1);
      end
      chk("hold8_score", int'(o_score), 2);
      chk("hold8_pulses", pulses, 2);

      // Interrupted holds do not accumulate
      enter_play();
      hold_ticks(3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      hold_ticks(3);
      chk("partial_score", int'(o_score), 0);

      // Saturation at MAX_SCORE
      enter_play();
      hold_ticks(98 * HOLD);
      chk("pre_sat_score", int'(o_score), 98);
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         if (i == 4) chk("sat_reach", int'(o_score), 99);
      end
      chk("sat_score", int'(o_score), 99);
      chk("sat_pulses", pulses, 1);

      // Collision coincident with a completing tick
      enter_play();
      hold_ticks(5 * HOLD + 3);
      chk("pre_col_score", int'(o_score), 5);
      pulses = 0;
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("col_score", int'(o_score), 5);
      chk("col_over", int'(o_game_over), 1);
      chk("col_high", int'(o_high_score), 5);
      chk("col_pulses", pulses, 0);
      repeat (6) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("over_frozen", int'(o_score), 5);

      // Restart keeps the best score; restart while playing is ignored
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("restart_score", int'(o_score), 0);
      chk("restart_high", int'(o_high_score), 5);
      chk("restart_over", int'(o_game_over), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("play_restart_over", int'(o_game_over), 0);
      hold_ticks(3 * HOLD);
      chk("second_score", int'(o_score), 3);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("second_over", int'(o_game_over), 1);
      chk("second_high", int'(o_high_score), 5);

      // Reset from OVER clears everything
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      hold_ticks(7 * HOLD);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("pre_rst_high", int'(o_high_score), 7);
      chk("pre_rst_score", int'(o_score), 7);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("over_rst_score", int'(o_score), 0);
      chk("over_rst_high", int'(o_high_score), 0);
      chk("over_rst_over", int'(o_game_over), 0);
      chk("over_rst_pulse", int'(o_score_pulse), 0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("ready_idle_over", int'(o_game_over), 0);

      // Random play
      r_mv = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r_rst  = ($urandom_range(199) == 0);
         r_tick = ($urandom_range(1) == 1);
         r_col  = ($urandom_range(39) == 0);
         r_rs   = ($urandom_range(9) == 0);
         if ($urandom_range(9) == 0) r_mv = ~r_mv;
         step(r_rst, r_tick, r_mv, r_col, r_rs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_score_counter
